fp_result_buffer: RTL and testbench
===================================

FP_RESULT_BUFFER -- requirements
Module: fp_result_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 2, giving the number of buffer entries; it SHALL be a power of two and at least 2.
REQ-002 The block SHALL have clk  input  1  as its single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have rst_n  input  1  as an asynchronous, active-low reset.
REQ-004 The block SHALL have in_valid  input  1  to indicate that a result from the fadd/fsub stage is present.
REQ-005 The block SHALL have in_ready  output  1  to indicate that the buffer can accept an entry.
REQ-006 The block SHALL have in_result  input  32  carrying the fadd/fsub result word.
REQ-007 The block SHALL have in_flags  input  5  carrying exception flags with bit order [4]=NV, [3]=DZ, [2]=OF, [1]=UF, [0]=NX.
REQ-008 The block SHALL have in_mode_fp  input  1  where 1 means single precision and 0 means half precision, with the result in bits [15:0].
REQ-009 The block SHALL have out_valid  output  1  to indicate that the head entry is presented.
REQ-010 The block SHALL have out_ready  input  1  to indicate that the consumer accepts the head entry.
REQ-011 The block SHALL have out_result  output  32  carrying the head result.
REQ-012 The block SHALL have out_flags  output  5  carrying the head entry flags.
REQ-013 The block SHALL have out_mode_fp  output  1  carrying the head entry mode.
REQ-014 The block SHALL have flags_clr  input  1  as a synchronous clear of the sticky flags.
REQ-015 The block SHALL have sticky_flags  output  5  holding the OR of the flags of all accepted entries since the last clear.
REQ-016 The block SHALL have count  output  $clog2(DEPTH)+1  holding the current occupancy.

Function
REQ-017 A push SHALL occur when in_valid=1 and in_ready=1, and a pop SHALL occur when out_valid=1 and out_ready=1.
REQ-018 in_ready SHALL equal (count<DEPTH), be registered-state only, and never depend combinationally on out_ready.
REQ-019 out_valid SHALL equal (count!=0), and out_result, out_flags and out_mode_fp SHALL come from the entry at rd_ptr.
REQ-020 Latency SHALL be exactly 1 cycle: a push at edge N SHALL cause out_valid=1 after edge N, with no combinational in-to-out path.
REQ-021 On push, if in_mode_fp=0 the stored result SHALL be {16'h0000, in_result[15:0]}; otherwise it SHALL be in_result unchanged.
REQ-022 The head entry outputs SHALL remain stable while out_valid=1 and out_ready=0.
REQ-023 wr_ptr and rd_ptr SHALL each be log2(DEPTH) bits and wrap modulo DEPTH.
REQ-024 A simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-025 A push alone SHALL increment count, and a pop alone SHALL decrement count.
REQ-026 When full (count=DEPTH), in_ready SHALL be 0 and in_valid SHALL be ignored even if a pop occurs in the same cycle.
REQ-027 When empty, out_ready SHALL be ignored, and a push in that cycle SHALL make the entry visible the next cycle.
REQ-028 Sticky flags SHALL update at push time, not pop time: sticky_flags <= sticky_flags | in_flags.
REQ-029 If flags_clr=1 with a push, sticky_flags SHALL become in_flags; if flags_clr=1 without a push, sticky_flags SHALL become 0.

Reset
REQ-030 While rst_n=0, count, wr_ptr, rd_ptr and sticky_flags SHALL be 0, out_valid SHALL be 0 and in_ready SHALL be 1, asynchronously.
REQ-031 Buffer storage SHALL NOT be reset, and out_result, out_flags and out_mode_fp SHALL be don't-care while out_valid=0.
REQ-032 A reset asserted mid-operation SHALL discard all held entries, with no partial pop or push completing.

Structure
REQ-033 Package fp_pkg SHALL hold the constants FP_DATA_W=32, FP_FLAG_W=5, the flag bit indices FLAG_NV..FLAG_NX and the encodings MODE_SP=1 and MODE_HP=0.
REQ-034 The storage array SHALL be one sub-module, fp_buf_mem (DEPTH x 38 bits, one write port and one asynchronous read port), with pointer and count control in fp_result_buffer.

Verification
REQ-035 The bench SHALL check: after reset, push {32'h3F800000, flags 5'b00001, SP} with out_ready=1 -> next cycle out_result=32'h3F800000, out_flags=1, sticky_flags=5'b00001.
REQ-036 The bench SHALL check: push half-mode result 32'hABCD3C00 -> out_result=32'h00003C00 and out_mode_fp=0.
REQ-037 The bench SHALL check: with DEPTH=2 and out_ready=0, push A and B -> in_ready=0 and count=2; raising out_ready pops A and then B, in order.
REQ-038 The bench SHALL check: with count=1, a simultaneous push and pop for 10 cycles -> count stays 1 and the pointers wrap without data loss.
REQ-039 The bench SHALL check: sticky_flags=5'b00100 and flags_clr with a push of flags 5'b10000 -> sticky_flags=5'b10000; flags_clr alone -> 0.
REQ-040 The bench SHALL check: rst_n deasserted mid-cycle with count=2 -> out_valid=0 and count=0 immediately, and in_ready=1.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared constants and the entry layout for the FP result buffer.
// Entries carry the result word, the exception flags and the precision mode.
package fp_pkg;

  localparam int FP_DATA_W = 32;
  localparam int FP_FLAG_W = 5;
  localparam int FP_ENTRY_W = FP_DATA_W + FP_FLAG_W + 1;

  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  localparam logic MODE_SP = 1'b1;
  localparam logic MODE_HP = 1'b0;

  typedef struct packed {
    logic [FP_DATA_W-1:0] result;
    logic [FP_FLAG_W-1:0] flags;
    logic                 mode_fp;
  } fp_entry_t;

  // Half results live in the low half; the upper half is forced to zero.
  function automatic logic [FP_DATA_W-1:0] fp_norm_result(
    input logic [FP_DATA_W-1:0] result,
    input logic                 mode_fp
  );
    if (mode_fp == MODE_SP)
      return result;
    return {16'h0000, result[15:0]};
  endfunction

endpackage

// File: rtl/fp_buf_mem.sv
// Entry storage: one synchronous write port, one asynchronous read port.
// Contents are intentionally not reset.
module fp_buf_mem
  import fp_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            i_we,
  input  logic [AW-1:0]   i_waddr,
  input  fp_entry_t       i_wdata,
  input  logic [AW-1:0]   i_raddr,
  output fp_entry_t       o_rdata
);

  fp_entry_t r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we)
      r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fp_result_buffer.sv
// Result buffer between the fadd/fsub stage and writeback, with
// sticky exception flag accumulation at push time.
module fp_result_buffer
  import fp_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [FP_DATA_W-1:0] in_result,
  input  logic [FP_FLAG_W-1:0] in_flags,
  input  logic                 in_mode_fp,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [FP_DATA_W-1:0] out_result,
  output logic [FP_FLAG_W-1:0] out_flags,
  output logic                 out_mode_fp,
  input  logic                 flags_clr,
  output logic [FP_FLAG_W-1:0] sticky_flags,
  output logic [CW-1:0]        count
);

  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [AW-1:0]        r_wr_ptr;
  logic [AW-1:0]        r_rd_ptr;
  logic [CW-1:0]        r_count;
  logic [FP_FLAG_W-1:0] r_sticky;

  logic      w_push;
  logic      w_pop;
  fp_entry_t w_wdata;
  fp_entry_t w_head;

  // Ready and valid derive only from the occupancy register.
  assign in_ready  = (r_count != FULL);
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;

  assign w_wdata.result  = fp_norm_result(in_result, in_mode_fp);
  assign w_wdata.flags   = in_flags;
  assign w_wdata.mode_fp = in_mode_fp;

  fp_buf_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_wdata),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_head)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push)
        r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_sticky <= '0;
    else if (flags_clr)
      r_sticky <= w_push ? in_flags : '0;
    else if (w_push)
      r_sticky <= r_sticky | in_flags;
  end

  assign out_result   = w_head.result;
  assign out_flags    = w_head.flags;
  assign out_mode_fp  = w_head.mode_fp;
  assign sticky_flags = r_sticky;
  assign count        = r_count;

endmodule

// File: tb/tb_fp_result_buffer.sv
// Self-checking bench for fp_result_buffer against a queue-based model.
// Directed scenarios first, then randomized traffic.
module tb_fp_result_buffer;

  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  typedef struct {
    logic [31:0] result;
    logic [4:0]  flags;
    logic        mode;
  } ref_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_result;
  logic [4:0]    in_flags;
  logic          in_mode_fp;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_result;
  logic [4:0]    out_flags;
  logic          out_mode_fp;
  logic          flags_clr;
  logic [4:0]    sticky_flags;
  logic [CW-1:0] count;

  int   n_checks = 0;
  int   n_fail   = 0;
  ref_t q[$];
  logic [4:0] m_sticky;

  fp_result_buffer #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_result    (in_result),
    .in_flags     (in_flags),
    .in_mode_fp   (in_mode_fp),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_flags    (out_flags),
    .out_mode_fp  (out_mode_fp),
    .flags_clr    (flags_clr),
    .sticky_flags (sticky_flags),
    .count        (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    check("count", 32'(count), 32'(q.size()));
    check("out_valid", 32'(out_valid), 32'(q.size() != 0));
    check("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
    check("sticky", 32'(sticky_flags), 32'(m_sticky));
    if (q.size() != 0) begin
      check("head_result", out_result, q[0].result);
      check("head_flags", 32'(out_flags), 32'(q[0].flags));
      check("head_mode", 32'(out_mode_fp), 32'(q[0].mode));
    end
  endtask

  // Inputs are set by the caller; check mid-cycle, then model the edge.
  task automatic step();
    bit   do_push, do_pop;
    ref_t e;
    @(negedge clk);
    check_state();
    do_push = in_valid && (q.size() < DEPTH);
    do_pop  = out_ready && (q.size() != 0);
    e.result = in_mode_fp ? in_result : {16'h0000, in_result[15:0]};
    e.flags  = in_flags;
    e.mode   = in_mode_fp;
    @(posedge clk);
    if (do_pop)
      void'(q.pop_front());
    if (do_push)
      q.push_back(e);
    if (flags_clr)
      m_sticky = do_push ? in_flags : 5'b0;
    else if (do_push)
      m_sticky = m_sticky | in_flags;
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] r,
                       input logic [4:0] f, input logic m);
    in_valid   = v;
    in_result  = r;
    in_flags   = f;
    in_mode_fp = m;
  endtask

  initial begin
    rst_n     = 1'b0;
    out_ready = 1'b0;
    flags_clr = 1'b0;
    drive(1'b0, 32'h0, 5'h0, 1'b1);
    m_sticky = 5'b0;
    #12;
    check("rst_count", 32'(count), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_sticky", 32'(sticky_flags), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single-precision push becomes visible the next cycle.
    out_ready = 1'b1;
    drive(1'b1, 32'h3F800000, 5'b00001, 1'b1);
    step();
    check("sp_result", out_result, 32'h3F800000);
    check("sp_flags", 32'(out_flags), 32'd1);
    check("sp_sticky", 32'(sticky_flags), 32'h01);
    drive(1'b0, 32'h0, 5'h0, 1'b1);
    step();

    // Half-precision push zeroes the upper half.
    drive(1'b1, 32'hABCD3C00, 5'b00000, 1'b0);
    step();
    check("hp_result", out_result, 32'h00003C00);
    check("hp_mode", 32'(out_mode_fp), 32'd0);
    drive(1'b0, 32'h0, 5'h0, 1'b1);
    step();

    // Fill with consumer stalled, then drain in order.
    out_ready = 1'b0;
    drive(1'b1, 32'h11111111, 5'b00010, 1'b1);
    step();
    drive(1'b1, 32'h22222222, 5'b01000, 1'b1);
    step();
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_count", 32'(count), 32'd2);
    drive(1'b1, 32'h33333333, 5'b10000, 1'b1);
    step();
    check("full_ignored", out_result, 32'h11111111);
    drive(1'b0, 32'h0, 5'h0, 1'b1);
    out_ready = 1'b1;
    check("drain_a", out_result, 32'h11111111);
    step();
    check("drain_b", out_result, 32'h22222222);
    step();
    check("drain_empty", 32'(out_valid), 32'd0);

    // Ten cycles of simultaneous push and pop at occupancy one.
    drive(1'b1, 32'h40000000, 5'b0, 1'b1);
    step();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'h40000001 + 32'(i), 5'b0, 1'b1);
      step();
      check("pp_count", 32'(count), 32'd1);
      check("pp_data", out_result, 32'h40000001 + 32'(i));
    end
    drive(1'b0, 32'h0, 5'h0, 1'b1);
    step();

    // Sticky clear semantics.
    flags_clr = 1'b1;
    drive(1'b1, 32'h1, 5'b00100, 1'b1);
    step();
    check("sticky_set", 32'(sticky_flags), 32'h04);
    drive(1'b1, 32'h2, 5'b10000, 1'b1);
    step();
    check("clr_push", 32'(sticky_flags), 32'h10);
    drive(1'b0, 32'h0, 5'h0, 1'b1);
    step();
    check("clr_alone", 32'(sticky_flags), 32'h00);
    flags_clr = 1'b0;
    step();

    // Asynchronous reset while holding two entries.
    out_ready = 1'b0;
    drive(1'b1, 32'hAAAA0001, 5'b00011, 1'b1);
    step();
    step();
    check("pre_rst_count", 32'(count), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_ready", 32'(in_ready), 32'd1);
    check("mid_rst_sticky", 32'(sticky_flags), 32'd0);
    q.delete();
    m_sticky = 5'b0;
    drive(1'b0, 32'h0, 5'h0, 1'b1);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom(),
            5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      out_ready = $urandom_range(0, 2) != 0;
      flags_clr = $urandom_range(0, 15) == 0;
      step();
    end
    flags_clr = 1'b0;
    drive(1'b0, 32'h0, 5'h0, 1'b1);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got stuck expected finish");
    $fatal(1);
  end

endmodule
